// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift request scheduler.
//   state_t   : scheduler FSM states
//   MAX_CHUNK : largest shift the combinational stage performs in one pass
//   LR_LEFT   : req_lr encoding for a left shift
//   AL_ARITH  : req_al encoding for an arithmetic right shift
package shift_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int   MAX_CHUNK = 7;
  localparam logic LR_LEFT   = 1'b1;
  localparam logic AL_ARITH  = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// Combinational 8-bit shifter, one pass of 0..7 bits.
//   din   : operand
//   shamt : shift amount for this pass
//   lr    : 1 = left, 0 = right
//   al    : right shifts only, 1 = arithmetic, 0 = logical
//   dout  : shifted operand
module shift_stage
  import shift_sched_pkg::*;
(
  input  logic [7:0] din,
  input  logic [2:0] shamt,
  input  logic       lr,
  input  logic       al,
  output logic [7:0] dout
);

  always_comb begin
    dout = din;
    if (lr == LR_LEFT)
      dout = din << shamt;
    else if (al == AL_ARITH)
      dout = $signed(din) >>> shamt;
    else
      dout = din >> shamt;
  end

endmodule

// File: rtl/shift_req_sched.sv
// Round-robin scheduler sharing one 8-bit shift stage among NREQ requesters.
// One operation in flight; amounts above 7 are applied as repeated passes.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_din/req_shamt   : packed operands, requester i in slice i
//   req_lr/req_al       : direction (1 = left) and right-shift kind (1 = arith)
//   resp_valid/ready    : result handshake
//   resp_dout/resp_id   : result and the requester it belongs to
//   busy                : any state other than IDLE
//   op_count            : completed responses, wrapping
module shift_req_sched
  import shift_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int SHAMT_W = 5,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*8-1:0]       req_din,
  input  logic [NREQ*SHAMT_W-1:0] req_shamt,
  input  logic [NREQ-1:0]         req_lr,
  input  logic [NREQ-1:0]         req_al,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [7:0]              resp_dout,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy,
  output logic [15:0]             op_count
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, grant, id;
  logic                any_req;
  logic [7:0]          work, stage_out;
  logic [SHAMT_W-1:0]  remaining, rem_nxt;
  logic [2:0]          chunk;
  logic                lr, al;
  int                  arb_idx;

  // Search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    arb_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      arb_idx = int'(rr_ptr) + i;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!any_req && req_valid[arb_idx]) begin
        grant   = ID_W'(arb_idx);
        any_req = 1'b1;
      end
    end
  end

  // A zero amount still yields one pass with chunk 0, which lands in RESP.
  assign chunk   = (remaining > SHAMT_W'(MAX_CHUNK)) ? 3'(MAX_CHUNK) : remaining[2:0];
  assign rem_nxt = remaining - SHAMT_W'(chunk);

  shift_stage u_stage (
    .din   (work),
    .shamt (chunk),
    .lr    (lr),
    .al    (al),
    .dout  (stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        // Async reset leaves state at IDLE, so ready must also be held off by rst.
        if (any_req && !rst) begin
          req_ready[grant] = 1'b1;
          state_nxt        = SHIFT;
        end
      end
      SHIFT:   if (rem_nxt == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      work      <= '0;
      remaining <= '0;
      lr        <= 1'b0;
      al        <= 1'b0;
      id        <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          work      <= req_din[int'(grant)*8 +: 8];
          remaining <= req_shamt[int'(grant)*SHAMT_W +: SHAMT_W];
          lr        <= req_lr[grant];
          al        <= req_al[grant];
          id        <= grant;
          rr_ptr    <= (grant == ID_W'(NREQ-1)) ? '0 : grant + 1'b1;
        end
        SHIFT: begin
          work      <= stage_out;
          remaining <= rem_nxt;
        end
        RESP: if (resp_ready) op_count <= op_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_dout  = resp_valid ? work : '0;
  assign resp_id    = resp_valid ? id : '0;
  assign busy       = (state != IDLE);

endmodule

// File: doc/shift_req_sched.md
Name: shift_req_sched

Overview:
- Round-robin scheduler sharing one 8-bit barrel-shift stage among NREQ requesters.
- Holds at most one operation in flight.
- Sequences shift amounts larger than 7 as repeated passes of at most 7 bits each through a combinational shift stage.
- Returns the result with the requester ID over a valid/ready response channel. Sits between the pipeline's shift-issuing units and the shift datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SHAMT_W, 5, shift-amount width; amounts range 0..2^SHAMT_W-1.
- ID_W, $clog2(NREQ), localparam, requester ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_din  in  NREQ*8  operand, requester i at bits [8i+7:8i].
- req_shamt  in  NREQ*SHAMT_W  shift amount per requester.
- req_lr  in  NREQ  1 = left shift, 0 = right shift.
- req_al  in  NREQ  right shifts only: 1 = arithmetic, 0 = logical; ignored for left shifts.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_dout  out  8  shifted result.
- resp_id  out  ID_W  index of the requester that issued the operation.
- busy  out  1  high whenever state != IDLE.
- op_count  out  16  completed responses; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset: state = IDLE, rr_ptr = 0, work/remaining/id registers = 0.
- Outputs during reset: req_ready = 0, resp_valid = 0, resp_dout = 0, resp_id = 0, busy = 0, op_count = 0.
- Reset mid-operation discards the in-flight operation; no response is produced.
- FSM states: IDLE, SHIFT, RESP.
- IDLE arbitration:
  - Arbiter searches req_valid starting at rr_ptr, ascending with wrap; grant = first set bit.
  - req_ready[grant] = 1 combinationally, only in IDLE and only when some req_valid is set.
  - On that edge: capture din into work, shamt into remaining, lr/al/id; rr_ptr <= (grant+1) mod NREQ; go to SHIFT.
- Requester rules: requesters hold valid and operands stable until ready. Inputs are sampled only on the accepting edge.
- SHIFT, per cycle:
  - chunk = min(remaining, 7).
  - work <= stage(work, chunk, lr, al); remaining <= remaining - chunk.
  - If remaining - chunk == 0, go to RESP.
- Shift amount 0 still takes one pass with chunk 0, so passes = max(1, ceil(shamt/7)).
- Latency: accept at edge E0; resp_valid is high in the cycle after edge E0+passes.
- Results for shamt >= 8:
  - Left and logical right give 0x00.
  - Arithmetic right gives 0xFF if din[7] = 1, else 0x00.
  - Iteration produces these naturally; no special-casing.
- RESP:
  - resp_valid = 1, resp_dout = work, resp_id = captured id, all held stable while resp_ready = 0.
  - On the edge with resp_ready = 1: op_count += 1, go to IDLE.
  - resp_valid drops the following cycle.
  - No new grant in the same cycle as RESP completion; minimum issue interval is passes+2 cycles.
- No requests valid in IDLE: stay in IDLE, rr_ptr unchanged.
- resp_ready asserted outside RESP: ignored.

Decomposition:
- Package shift_sched_pkg holds:
  - State enum {IDLE, SHIFT, RESP}.
  - Constant MAX_CHUNK = 7.
  - LR_LEFT = 1, AL_ARITH = 1.
- Sub-module shift_stage: purely combinational 8-bit shifter.
  - Inputs din[7:0], shamt[2:0], lr, al; output dout[7:0].
  - Implements logical left, logical right and arithmetic right.
  - Instantiated once in the scheduler.

Test Plan:
- Req1 only: din 0xB4, shamt 2, lr 0, al 1 -> resp_dout 0xED, resp_id 1, resp_valid in the cycle after the edge following accept.
- Req0: din 0xB4, shamt 2, lr 0, al 0 -> 0x2D; then din 0x81, shamt 1, lr 1 -> 0x02; then din 0x5A, shamt 0 -> 0x5A after 1 pass.
- Req2: din 0x80, shamt 10, lr 0, al 1 -> 0xFF after 2 passes; same with al 0 -> 0x00; shamt 31, lr 1 -> 0x00 after 5 passes.
- Round robin: req0 and req2 valid continuously, rr_ptr 0 -> grants 0, 2, 0, 2. Then add req3 after grant 2 (rr_ptr 3) -> next grant 3, then 0.
- Backpressure: resp_ready held low 5 cycles in RESP -> resp_dout/resp_id stable, busy = 1, no req_ready asserted, op_count increments exactly once on release.
- Reset asserted mid-SHIFT of a shamt-20 op -> all outputs 0 immediately; after release a new request completes correctly with rr_ptr restarted at 0.
